// File: rtl/pipe_throttle_pkg.sv
// rtl/pipe_throttle_pkg.sv - shared types and helpers for the pipe block throttle
package pipe_throttle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    XFER   = 2'd2,
    SETTLE = 2'd3
  } ch_state_e;

  localparam int DIR_IN  = 0;
  localparam int DIR_OUT = 1;

  // One extra bit so the counter can hold BLOCK_WORDS itself without wrapping.
  function automatic int word_cnt_width(input int block_words);
    return $clog2(block_words) + 1;
  endfunction

endpackage

// File: rtl/pipe_throttle_ch.sv
// rtl/pipe_throttle_ch.sv - one channel-direction: ready FSM, word/settle counters, sticky errors
module pipe_throttle_ch
  import pipe_throttle_pkg::*;
#(
  parameter int DIR         = DIR_IN,
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = 128,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] fill_count,
  input  logic             strobe,
  input  logic             blockstrobe,
  input  logic             err_clr,
  output logic             ready,
  output logic             flow_err,
  output logic             proto_err
);

  localparam int WC_W = word_cnt_width(BLOCK_WORDS);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W:0]  IN_LIMIT  = (CNT_W+1)'(DEPTH - BLOCK_WORDS);
  localparam logic [CNT_W:0]  OUT_LIMIT = (CNT_W+1)'(BLOCK_WORDS);
  localparam logic [CNT_W:0]  DEPTH_EXT = (CNT_W+1)'(DEPTH);
  localparam logic [WC_W-1:0] WC_FULL   = WC_W'(BLOCK_WORDS);
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SETTLE_CYC - 1);

  ch_state_e       state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [SC_W-1:0] scnt_q, scnt_d;
  logic            ready_q, ready_d;
  logic            flow_q, flow_d;
  logic            proto_q, proto_d;
  logic [CNT_W:0]  fill_ext;
  logic            space_ok;
  logic            proto_hit;
  logic            flow_hit;

  assign fill_ext = {1'b0, fill_count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      ready_q <= 1'b0;
      flow_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      ready_q <= ready_d;
      flow_q  <= flow_d;
      proto_q <= proto_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    scnt_d    = scnt_q;
    proto_hit = 1'b0;
    if (DIR == DIR_IN) space_ok = (fill_ext <= IN_LIMIT);
    else               space_ok = (fill_ext >= OUT_LIMIT);
    case (state_q)
      IDLE: begin
        proto_hit = strobe | blockstrobe;
        if (enable && space_ok) state_d = READY;
      end
      READY: begin
        // A blockstrobe wins over a same-cycle loss of space: the host saw ready high.
        if (blockstrobe) begin
          state_d = XFER;
          wcnt_d  = {{(WC_W-1){1'b0}}, strobe};
        end else begin
          proto_hit = strobe;
          if (!enable || !space_ok) state_d = IDLE;
        end
      end
      XFER: begin
        if (blockstrobe) begin
          proto_hit = 1'b1;
          wcnt_d    = {{(WC_W-1){1'b0}}, strobe};
        end else if (strobe) begin
          if (wcnt_q == WC_FULL) proto_hit = 1'b1;
          else                   wcnt_d = wcnt_q + WC_W'(1);
        end
        if (wcnt_d == WC_FULL) begin
          state_d = SETTLE;
          scnt_d  = '0;
        end
      end
      SETTLE: begin
        proto_hit = strobe | blockstrobe;
        if (scnt_q == SC_LAST) state_d = IDLE;
        else                   scnt_d  = scnt_q + SC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (DIR == DIR_IN) flow_hit = strobe & (fill_ext >= DEPTH_EXT);
    else               flow_hit = strobe & (fill_count == '0);
    ready_d = (state_q == READY);
    flow_d  = flow_hit  | (flow_q  & ~err_clr);
    proto_d = proto_hit | (proto_q & ~err_clr);
  end

  assign ready     = ready_q;
  assign flow_err  = flow_q;
  assign proto_err = proto_q;

endmodule

// File: rtl/pipe_block_throttle.sv
// rtl/pipe_block_throttle.sv - multi-channel block-flow controller for host pipe endpoints
module pipe_block_throttle
  import pipe_throttle_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int IN_DEPTH    = 1024,
  parameter int OUT_DEPTH   = 1024,
  parameter int CNT_W       = 11,
  parameter int BLOCK_WORDS = 128,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] in_wr_count,
  input  logic [NUM_CH-1:0]       in_write,
  input  logic [NUM_CH-1:0]       in_blockstrobe,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*CNT_W-1:0] out_rd_count,
  input  logic [NUM_CH-1:0]       out_read,
  input  logic [NUM_CH-1:0]       out_blockstrobe,
  output logic [NUM_CH-1:0]       out_ready,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       in_overrun,
  output logic [NUM_CH-1:0]       out_underrun,
  output logic [NUM_CH-1:0]       proto_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic in_proto;
    logic out_proto;

    pipe_throttle_ch #(
      .DIR         (DIR_IN),
      .DEPTH       (IN_DEPTH),
      .BLOCK_WORDS (BLOCK_WORDS),
      .SETTLE_CYC  (SETTLE_CYC),
      .CNT_W       (CNT_W)
    ) u_in (
      .clk         (clk),
      .rst_n       (reset_n),
      .enable      (ch_enable[i]),
      .fill_count  (in_wr_count[i*CNT_W +: CNT_W]),
      .strobe      (in_write[i]),
      .blockstrobe (in_blockstrobe[i]),
      .err_clr     (err_clr),
      .ready       (in_ready[i]),
      .flow_err    (in_overrun[i]),
      .proto_err   (in_proto)
    );

    pipe_throttle_ch #(
      .DIR         (DIR_OUT),
      .DEPTH       (OUT_DEPTH),
      .BLOCK_WORDS (BLOCK_WORDS),
      .SETTLE_CYC  (SETTLE_CYC),
      .CNT_W       (CNT_W)
    ) u_out (
      .clk         (clk),
      .rst_n       (reset_n),
      .enable      (ch_enable[i]),
      .fill_count  (out_rd_count[i*CNT_W +: CNT_W]),
      .strobe      (out_read[i]),
      .blockstrobe (out_blockstrobe[i]),
      .err_clr     (err_clr),
      .ready       (out_ready[i]),
      .flow_err    (out_underrun[i]),
      .proto_err   (out_proto)
    );

    assign proto_err[i] = in_proto | out_proto;
  end

endmodule
